// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift_sequencer slice.
//   - shift_op_e  : shift-type encodings carried in shiftOperand[6:5]
//   - state_e     : sequencer FSM states
//   - field positions inside the 12-bit shiftOperand
//   - sign_extend12 helper for the load/store offset form
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // shiftOperand field positions
  localparam int unsigned AMT_MSB  = 11;  // register-form shift amount
  localparam int unsigned AMT_LSB  = 7;
  localparam int unsigned TYPE_MSB = 6;   // shift type
  localparam int unsigned TYPE_LSB = 5;
  localparam int unsigned ROT_MSB  = 11;  // immediate-form rotate field
  localparam int unsigned ROT_LSB  = 8;
  localparam int unsigned IMM8_MSB = 7;   // immediate-form 8-bit value
  localparam int unsigned IMM8_LSB = 0;

  // Width of the per-cycle step amount; holds 0..8, the largest legal STEP.
  localparam int unsigned STEP_AMT_W = 4;

  function automatic logic [31:0] sign_extend12(input logic [11:0] field);
    return {{20{field[11]}}, field};
  endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step_unit: combinational narrow shifter, moves a 32-bit value by
// 0..STEP positions in one cycle.
// Ports:
//   op       in   2   shift type (LSL/LSR/ASR/ROR)
//   value    in  32   value to shift
//   amount   in   4   positions to shift this cycle, 0..STEP
//   result   out 32   shifted value (value itself for amount 0)
//   last_out out  1   last bit shifted/rotated out (0 for amount 0)
module shift_step_unit
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic [1:0]            op,
  input  logic [31:0]           value,
  input  logic [STEP_AMT_W-1:0] amount,
  output logic [31:0]           result,
  output logic                  last_out
);

  // One constant-distance shifter per legal amount, selected by a mux;
  // keeps the logic to STEP small shifters instead of a 32-way barrel.
  always_comb begin
    result   = value;
    last_out = 1'b0;
    for (int unsigned k = 1; k <= STEP; k++) begin
      if (amount == STEP_AMT_W'(k)) begin
        case (shift_op_e'(op))
          LSL: begin
            result   = value << k;
            last_out = value[32-k];
          end
          LSR: begin
            result   = value >> k;
            last_out = value[k-1];
          end
          ASR: begin
            result   = 32'($signed(value) >>> k);
            last_out = value[k-1];
          end
          default: begin
            result   = (value >> k) | (value << (32 - k));
            last_out = value[k-1];
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle generator of the second ALU operand (val2)
// from valRm and the 12-bit shift-operand field, using an iterative shifter
// of at most STEP positions per cycle.
// Optional feature macro: SHIFT_CARRY_OUT_EN adds carryIn/carryOut.
// Ports:
//   clk                in   1   rising-edge clock
//   rst_n              in   1   asynchronous active-low reset
//   startValid         in   1   operand request valid
//   startReady         out  1   sequencer idle, request can be accepted
//   valRm              in  32   register operand
//   shiftOperand       in  12   instruction bits [11:0]
//   imm                in   1   rotated 8-bit immediate form
//   memoryInstruction  in   1   load/store offset form (highest priority)
//   flush              in   1   synchronous abort to IDLE
//   resultValid        out  1   val2 valid
//   resultReady        in   1   consumer accepts val2
//   val2               out 32   generated operand
//   busy               out  1   not IDLE, used for hazard stall
//   carryIn            in   1   (SHIFT_CARRY_OUT_EN) carry sampled at accept
//   carryOut           out  1   (SHIFT_CARRY_OUT_EN) last bit shifted out
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP  = 4,
  parameter int unsigned CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        startValid,
  output logic        startReady,
  input  logic [31:0] valRm,
  input  logic [11:0] shiftOperand,
  input  logic        imm,
  input  logic        memoryInstruction,
  input  logic        flush,
  output logic        resultValid,
  input  logic        resultReady,
  output logic [31:0] val2,
  output logic        busy
`ifdef SHIFT_CARRY_OUT_EN
  ,
  input  logic        carryIn,
  output logic        carryOut
`endif
);

  state_e                  state, state_next;
  shift_op_e               op, op_next;
  logic [31:0]             working, working_next;
  logic [CNT_W-1:0]        counter, counter_next;
  logic                    load_val2;

  logic [31:0]             accept_working;
  logic [CNT_W-1:0]        accept_counter;
  shift_op_e               accept_op;

  logic [STEP_AMT_W-1:0]   step_amt;
  logic [31:0]             step_result;
  logic                    step_last;

`ifdef SHIFT_CARRY_OUT_EN
  logic                    carry, carry_next;
`endif

  // Request decode, priority memoryInstruction > imm > register shift.
  always_comb begin
    accept_working = valRm;
    accept_counter = CNT_W'(shiftOperand[AMT_MSB:AMT_LSB]);
    accept_op      = shift_op_e'(shiftOperand[TYPE_MSB:TYPE_LSB]);
    if (memoryInstruction) begin
      accept_working = sign_extend12(shiftOperand);
      accept_counter = '0;
      accept_op      = LSL;
    end else if (imm) begin
      accept_working = {24'd0, shiftOperand[IMM8_MSB:IMM8_LSB]};
      accept_counter = CNT_W'({shiftOperand[ROT_MSB:ROT_LSB], 1'b0});
      accept_op      = ROR;
    end
  end

  assign step_amt = (counter < CNT_W'(STEP)) ? STEP_AMT_W'(counter)
                                             : STEP_AMT_W'(STEP);

  shift_step_unit #(.STEP(STEP)) u_step (
    .op       (op),
    .value    (working),
    .amount   (step_amt),
    .result   (step_result),
    .last_out (step_last)
  );

  always_comb begin
    state_next   = state;
    op_next      = op;
    working_next = working;
    counter_next = counter;
    load_val2    = 1'b0;
`ifdef SHIFT_CARRY_OUT_EN
    carry_next   = carry;
`endif
    case (state)
      IDLE: begin
        if (startValid) begin
          op_next      = accept_op;
          working_next = accept_working;
          counter_next = accept_counter;
`ifdef SHIFT_CARRY_OUT_EN
          carry_next   = carryIn;
`endif
          if (accept_counter == '0) begin
            state_next = DONE;
            load_val2  = 1'b1;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        working_next = step_result;
        counter_next = counter - CNT_W'(step_amt);
`ifdef SHIFT_CARRY_OUT_EN
        carry_next   = step_last;
`endif
        if (counter_next == '0) begin
          state_next = DONE;
          load_val2  = 1'b1;
        end
      end
      DONE: begin
        if (resultReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush wins over everything, including the final SHIFT step: val2 keeps
    // the previous result rather than picking up the aborted one.
    if (flush) begin
      state_next = IDLE;
      load_val2  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= LSL;
      working <= '0;
      counter <= '0;
      val2    <= '0;
`ifdef SHIFT_CARRY_OUT_EN
      carry   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      op      <= op_next;
      working <= working_next;
      counter <= counter_next;
      if (load_val2) val2 <= working_next;
`ifdef SHIFT_CARRY_OUT_EN
      carry   <= carry_next;
`endif
    end
  end

  assign startReady  = (state == IDLE);
  assign resultValid = (state == DONE);
  assign busy        = (state != IDLE);

`ifdef SHIFT_CARRY_OUT_EN
  assign carryOut = carry;
`else
  logic unused_step_last;
  assign unused_step_last = step_last;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (STEP = 4): directed cases plus
// randomized requests compared against a behavioural operand model.
// Define SHIFT_CARRY_OUT_EN for both bench and RTL to also check carryOut.
module tb_shift_sequencer;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        startValid = 1'b0;
  logic        startReady;
  logic [31:0] valRm = '0;
  logic [11:0] shiftOperand = '0;
  logic        imm = 1'b0;
  logic        memoryInstruction = 1'b0;
  logic        flush = 1'b0;
  logic        resultValid;
  logic        resultReady = 1'b0;
  logic [31:0] val2;
  logic        busy;
`ifdef SHIFT_CARRY_OUT_EN
  logic        carryIn = 1'b0;
  logic        carryOut;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.STEP(STEP), .CNT_W(6)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .startValid        (startValid),
    .startReady        (startReady),
    .valRm             (valRm),
    .shiftOperand      (shiftOperand),
    .imm               (imm),
    .memoryInstruction (memoryInstruction),
    .flush             (flush),
    .resultValid       (resultValid),
    .resultReady       (resultReady),
    .val2              (val2),
    .busy              (busy)
`ifdef SHIFT_CARRY_OUT_EN
    ,
    .carryIn           (carryIn),
    .carryOut          (carryOut)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_edge;
    @(posedge clk);
    #1;
  endtask

  // Behavioural operand model: value, total shift amount and carry.
  task automatic model(input logic [31:0] rm, input logic [11:0] so,
                       input logic im, input logic mem, input logic cin,
                       output logic [31:0] v, output int amt, output logic c);
    int a;
    logic [31:0] x;
    if (mem) begin
      v = {{20{so[11]}}, so};
      amt = 0;
      c = cin;
    end else if (im) begin
      a = 2 * int'(so[11:8]);
      x = {24'd0, so[7:0]};
      v = (a == 0) ? x : ((x >> a) | (x << (32 - a)));
      c = (a == 0) ? cin : v[31];
      amt = a;
    end else begin
      a = int'(so[11:7]);
      amt = a;
      if (a == 0) begin
        v = rm;
        c = cin;
      end else begin
        case (so[6:5])
          2'b00: begin v = rm << a; c = rm[32-a]; end
          2'b01: begin v = rm >> a; c = rm[a-1]; end
          2'b10: begin v = $signed(rm) >>> a; c = rm[a-1]; end
          default: begin v = (rm >> a) | (rm << (32 - a)); c = rm[a-1]; end
        endcase
      end
    end
  endtask

  // Issue one request, check latency/result, hold DONE for 'hold' cycles
  // with a competing startValid, then release and check nothing was taken.
  task automatic run_op(input string tag, input logic [31:0] rm, input logic [11:0] so,
                        input logic im, input logic mem, input logic cin, input int hold);
    logic [31:0] ev;
    int amt;
    int lat;
    logic ec;
    model(rm, so, im, mem, cin, ev, amt, ec);
    valRm = rm;
    shiftOperand = so;
    imm = im;
    memoryInstruction = mem;
`ifdef SHIFT_CARRY_OUT_EN
    carryIn = cin;
`endif
    resultReady = 1'b0;
    startValid = 1'b1;
    check({tag, "/ready"}, 32'(startReady), 32'd1);
    wait_edge;
    startValid = 1'b0;
    // Scramble inputs after accept: the result must not depend on them.
    valRm = $urandom;
    shiftOperand = 12'($urandom);
    imm = 1'($urandom);
    memoryInstruction = 1'($urandom);
`ifdef SHIFT_CARRY_OUT_EN
    carryIn = 1'($urandom);
`endif
    lat = 1;
    while (!resultValid && lat < 64) begin
      wait_edge;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(1 + (amt + int'(STEP) - 1) / int'(STEP)));
    check({tag, "/val2"}, val2, ev);
`ifdef SHIFT_CARRY_OUT_EN
    check({tag, "/carry"}, 32'(carryOut), 32'(ec));
`endif
    for (int i = 0; i < hold; i++) begin
      startValid = 1'b1;
      wait_edge;
      check({tag, "/hold_val2"}, val2, ev);
      check({tag, "/hold_valid"}, 32'(resultValid), 32'd1);
    end
    resultReady = 1'b1;
    wait_edge;
    startValid = 1'b0;
    resultReady = 1'b0;
    check({tag, "/release"}, {30'd0, busy, resultValid}, 32'd0);
  endtask

  initial begin : main
    logic [31:0] prev;
    logic        saw_valid;
    int          mode;

    // Reset state
    wait_edge;
    check("reset/val2", val2, 32'd0);
    check("reset/valid_busy", {30'd0, resultValid, busy}, 32'd0);
    check("reset/ready", 32'(startReady), 32'd1);
    wait_edge;
    rst_n = 1'b1;
    wait_edge;

    // Directed cases
    run_op("lsl31", 32'h0000_0001, {5'd31, 2'b00, 5'd0}, 1'b0, 1'b0, 1'b1, 0);
    check("lsl31/exact", val2, 32'h8000_0000);

    // Reset pulsed mid-SHIFT
    valRm = 32'hF000_0000;
    shiftOperand = {5'd20, 2'b01, 5'd0};
    startValid = 1'b1;
    wait_edge;
    startValid = 1'b0;
    wait_edge;
    check("rst_mid/in_shift", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid/val2", val2, 32'd0);
    check("rst_mid/valid_busy", {30'd0, resultValid, busy}, 32'd0);
    wait_edge;
    rst_n = 1'b1;
    wait_edge;
    check("rst_mid/ready", 32'(startReady), 32'd1);

    run_op("asr4", 32'h8000_0000, {5'd4, 2'b10, 5'd0}, 1'b0, 1'b0, 1'b0, 0);
    check("asr4/exact", val2, 32'hF800_0000);
    run_op("imm", 32'h1234_5678, {4'd4, 8'hFF}, 1'b1, 1'b0, 1'b0, 0);
    check("imm/exact", val2, 32'hFF00_0000);
    run_op("mem", 32'h1234_5678, 12'h800, 1'b1, 1'b1, 1'b1, 0);
    check("mem/exact", val2, 32'hFFFF_F800);
    run_op("ror0", 32'hDEAD_BEEF, {5'd0, 2'b11, 5'd0}, 1'b0, 1'b0, 1'b1, 0);
    run_op("backpressure", 32'h0F0F_00FF, {5'd9, 2'b11, 5'd0}, 1'b0, 1'b0, 1'b0, 5);

    // Flush during SHIFT: back to IDLE, val2 unchanged, no resultValid pulse
    prev = val2;
    valRm = 32'hFFFF_FFFF;
    shiftOperand = {5'd20, 2'b01, 5'd0};
    imm = 1'b0;
    memoryInstruction = 1'b0;
    startValid = 1'b1;
    wait_edge;
    startValid = 1'b0;
    flush = 1'b1;
    wait_edge;
    flush = 1'b0;
    check("flush_shift/busy_valid", {30'd0, busy, resultValid}, 32'd0);
    check("flush_shift/val2", val2, prev);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_edge;
      saw_valid = saw_valid | resultValid;
    end
    check("flush_shift/no_pulse", 32'(saw_valid), 32'd0);

    // Flush beats startValid in IDLE
    startValid = 1'b1;
    flush = 1'b1;
    wait_edge;
    startValid = 1'b0;
    flush = 1'b0;
    check("flush_idle/dropped", {30'd0, busy, resultValid}, 32'd0);

    // Randomized requests
    for (int n = 0; n < 150; n++) begin
      mode = int'($urandom_range(0, 3));
      run_op("rand", $urandom, 12'($urandom),
             (mode == 1) ? 1'b1 : 1'($urandom) & (mode == 0),
             (mode == 0), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
